fp_convert_seq: RTL and testbench

- Multi-cycle sequencer that converts a 12-bit two's-complement linear sample into the team's 8-bit float format: sign, 3-bit exponent, 4-bit significand.
- Sequences three datapath steps: magnitude/sign extraction, iterative normalization (one shift per cycle), then round-with-carry.
- Sits between the sample source and the float consumer.
- Uses a valid/ready handshake on both sides, so either side can stall.

---
 rtl/fp_convert_seq_if.sv | 22 ++
 rtl/fp_convert_seq.sv | 175 +++++++++++++++++
 tb/tb_fp_convert_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fp_convert_seq_if.sv
// Valid/ready bundle between the sample source, the fp_convert_seq block and the float consumer.
// The slave modport is the converter's view; the master modport is the driving environment's view.
interface fp_convert_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [2:0]  out_exp;
  logic [3:0]  out_sig;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_sig
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_sig
  );
endinterface

// File: rtl/fp_convert_seq.sv
// 12-bit two's-complement to 8-bit float (sign, 3-bit exp, 4-bit sig) sequencer.
// Define FP_ROUND_EN for round-with-carry; otherwise the ROUND step truncates.
module fp_convert_seq (
  input  logic                   clk,
  input  logic                   rst_n,
  fp_convert_seq_if.slave        bus,
  output logic                   busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ABS   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [11:0] data_r;
  logic        sign_r;
  logic [10:0] mag_r;
  logic [2:0]  exp_r;
  logic        in_ready_r;
  logic        busy_r;
  logic        out_valid_r;
  logic        out_sign_r;
  logic [2:0]  out_exp_r;
  logic [3:0]  out_sig_r;
  logic [11:0] neg_s;
  logic [10:0] abs_mag_s;
  logic [2:0]  res_exp_s;
  logic [3:0]  res_sig_s;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sign  = out_sign_r;
  assign bus.out_exp   = out_exp_r;
  assign bus.out_sig   = out_sig_r;
  assign busy          = busy_r;

  // Magnitude of the captured sample; -2048 has no 11-bit magnitude and saturates.
  always_comb begin
    neg_s     = 12'd0 - data_r;
    abs_mag_s = data_r[10:0];
    if (data_r == 12'h800) begin
      abs_mag_s = 11'h7FF;
    end else if (data_r[11]) begin
      abs_mag_s = neg_s[10:0];
    end else begin
      abs_mag_s = data_r[10:0];
    end
  end

  // Result of the ROUND step from the normalized magnitude.
  always_comb begin
    res_exp_s = exp_r;
    res_sig_s = mag_r[10:7];
`ifdef FP_ROUND_EN
    if (mag_r[6] == 1'b0) begin
      res_exp_s = exp_r;
      res_sig_s = mag_r[10:7];
    end else if (mag_r[10:7] != 4'b1111) begin
      res_exp_s = exp_r;
      res_sig_s = mag_r[10:7] + 4'd1;
    end else if (exp_r != 3'd7) begin
      res_exp_s = exp_r + 3'd1;
      res_sig_s = 4'b1000;
    end else begin
      res_exp_s = 3'd7;
      res_sig_s = 4'b1111;
    end
`else
    res_exp_s = exp_r;
    res_sig_s = mag_r[10:7];
`endif
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          state_s = ABS;
        end else begin
          state_s = IDLE;
        end
      end
      ABS: state_s = NORM;
      NORM: begin
        if (mag_r[10] || (exp_r == 3'd0)) begin
          state_s = ROUND;
        end else begin
          state_s = NORM;
        end
      end
      ROUND: state_s = DONE;
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus the status flags that mirror it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == IDLE);
      busy_r     <= (state_s != IDLE);
    end
  end

  // Datapath and output registers, advanced one step per state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r      <= 12'd0;
      sign_r      <= 1'b0;
      mag_r       <= 11'd0;
      exp_r       <= 3'd0;
      out_valid_r <= 1'b0;
      out_sign_r  <= 1'b0;
      out_exp_r   <= 3'd0;
      out_sig_r   <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            data_r <= bus.in_data;
          end else begin
            data_r <= data_r;
          end
        end
        ABS: begin
          sign_r <= data_r[11];
          mag_r  <= abs_mag_s;
          exp_r  <= 3'd7;
        end
        NORM: begin
          if (mag_r[10] || (exp_r == 3'd0)) begin
            mag_r <= mag_r;
            exp_r <= exp_r;
          end else begin
            mag_r <= {mag_r[9:0], 1'b0};
            exp_r <= exp_r - 3'd1;
          end
        end
        ROUND: begin
          out_sign_r  <= sign_r;
          out_exp_r   <= res_exp_s;
          out_sig_r   <= res_sig_s;
          out_valid_r <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_convert_seq.sv
// Scoreboard bench for fp_convert_seq: directed samples push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_fp_convert_seq;

  logic clk;
  logic rst_n;
  logic busy;
  int   tests;
  int   fails;
  logic [7:0] sb_q[$];

  fp_convert_seq_if bus ();

  fp_convert_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FP_ROUND_EN
  localparam logic [7:0] E_07E = 8'b0_100_1000;
  localparam logic [7:0] E_FD2 = 8'b1_010_1100;
  localparam logic [7:0] E_02E = 8'b0_010_1100;
  localparam logic [7:0] E_0FF = 8'b0_101_1000;
`else
  localparam logic [7:0] E_07E = 8'b0_011_1111;
  localparam logic [7:0] E_FD2 = 8'b1_010_1011;
  localparam logic [7:0] E_02E = 8'b0_010_1011;
  localparam logic [7:0] E_0FF = 8'b0_100_1111;
`endif

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", int'({bus.out_sign, bus.out_exp, bus.out_sig}), -1);
      end else begin
        check("result", int'({bus.out_sign, bus.out_exp, bus.out_sig}), int'(sb_q.pop_front()));
      end
    end
  end

  // Issue one sample, then count edges until out_valid rises (accepting edge = 1).
  task automatic send(input logic [11:0] d, input int lat, input logic [7:0] e);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", int'(bus.in_ready), 1);
    sb_q.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, lat);
  endtask

  initial begin
    logic [7:0] held;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 12'd0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_outputs", int'({bus.out_sign, bus.out_exp, bus.out_sig}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(12'h000, 11, 8'b0_000_0000);
    send(12'h07E, 8,  E_07E);
    send(12'hFD2, 9,  E_FD2);
    send(12'h7FF, 4,  8'b0_111_1111);
    send(12'h800, 4,  8'b1_111_1111);
    send(12'h400, 4,  8'b0_111_1000);
    send(12'hC00, 4,  8'b1_111_1000);
    send(12'h0C0, 7,  8'b0_100_1100);
    send(12'h0FF, 7,  E_0FF);
    send(12'hFFF, 11, 8'b1_000_0001);
    send(12'h003, 11, 8'b0_000_0011);

    // Backpressure: result must hold while the consumer stalls.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(12'h07E, 8, E_07E);
    held = {bus.out_sign, bus.out_exp, bus.out_sig};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", int'(bus.out_valid), 1);
      check("bp_stable", int'({bus.out_sign, bus.out_exp, bus.out_sig}), int'(held));
      check("bp_in_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", int'(bus.out_valid), 0);
    check("bp_release_in_ready", int'(bus.in_ready), 1);
    check("bp_outputs_kept", int'({bus.out_sign, bus.out_exp, bus.out_sig}), int'(held));

    // Reset two cycles into NORM discards the sample entirely.
    bus.in_valid = 1'b1;
    bus.in_data  = 12'h001;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_outputs", int'({bus.out_sign, bus.out_exp, bus.out_sig}), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(12'h02E, 9, E_02E);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
